// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: mode encodings,
// default parameters and small mode-decode helpers.
package tick_pkg;

    localparam int DEF_PRESCALE = 1000;
    localparam int DEF_CH       = 4;
    localparam int DEF_DIV_W    = 8;

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_TOGGLE   = 2'b10
    } mode_e;

    // Encoding 2'b11 falls through both helpers and behaves as periodic.
    function automatic logic is_oneshot(input logic [1:0] mode);
        return mode == MODE_ONESHOT;
    endfunction

    function automatic logic is_toggle(input logic [1:0] mode);
        return mode == MODE_TOGGLE;
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Control and status bundle of the tick generator; master drives the
// configuration, slave is the generator itself.
interface tick_gen_if
    import tick_pkg::*;
#(
    parameter int CH    = DEF_CH,
    parameter int DIV_W = DEF_DIV_W
) ();

    logic                en;
    logic [CH*DIV_W-1:0] div_i;
    logic [CH*2-1:0]     mode_i;
    logic [CH-1:0]       start_i;
    logic [CH-1:0]       tick_o;
    logic [CH-1:0]       wave_o;
    logic [CH-1:0]       busy_o;

    modport master (
        output en, div_i, mode_i, start_i,
        input  tick_o, wave_o, busy_o
    );

    modport slave (
        input  en, div_i, mode_i, start_i,
        output tick_o, wave_o, busy_o
    );

endinterface

// File: rtl/tick_gen_chan.sv
// One tick channel: divides the shared base strobe by a live divisor and
// produces a one-clock tick, a toggle wave and a busy flag.
module tick_chan
    import tick_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic             tick,
    output logic             wave,
    output logic             busy
);

    logic [DIV_W-1:0] ccnt;
    logic             os_busy;
    logic             div_nz;
    logic             oneshot;
    logic             wrap;

    assign div_nz  = |div;
    assign oneshot = is_oneshot(mode);

    // Busy is decoded from live divisor/mode plus the one-shot flag, so the
    // reset value follows the configuration without a config-dependent reset.
    assign busy = div_nz && (!oneshot || os_busy);

    // >= rather than == so a live decrease of the divisor wraps on the next strobe.
    assign wrap = strobe && busy && (ccnt >= div - DIV_W'(1));

    // NOTE: every flop here resets asynchronously and is written with <=;
    // later assignments in the block intentionally override earlier ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccnt    <= '0;
            os_busy <= 1'b0;
            tick    <= 1'b0;
            wave    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!div_nz) begin
                ccnt    <= '0;
                os_busy <= 1'b0;
            end else if (start) begin
                // Start beats a coincident wrap: resync with no tick.
                ccnt    <= '0;
                os_busy <= oneshot;
            end else if (wrap) begin
                ccnt <= '0;
                tick <= 1'b1;
                if (is_toggle(mode)) begin
                    wave <= ~wave;
                end
                if (oneshot) begin
                    os_busy <= 1'b0;
                end
            end else if (strobe && busy) begin
                ccnt <= ccnt + 1'b1;
            end
            // Leaving one-shot drops the armed flag so re-entry waits for start.
            if (!oneshot) begin
                os_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator top: shared prescaler producing the base
// strobe, fanned out to CH independent divider channels.
module tick_gen
    import tick_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int CH       = DEF_CH,
    parameter int DIV_W    = DEF_DIV_W
) (
    input logic        clk,
    input logic        rst_n,
    tick_gen_if.slave  bus
);

    localparam int              PW    = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;
    logic          strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (bus.en) begin
            pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
        end
    end

    assign strobe = bus.en && (pcnt == PLAST);

    for (genvar k = 0; k < CH; k++) begin : g_chan
        tick_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .strobe (strobe),
            .div    (bus.div_i[k*DIV_W +: DIV_W]),
            .mode   (bus.mode_i[2*k +: 2]),
            .start  (bus.start_i[k]),
            .tick   (bus.tick_o[k]),
            .wave   (bus.wave_o[k]),
            .busy   (bus.busy_o[k])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen with PRESCALE = 4: a vector table for the mixed
// four-channel run plus hand sequences for enable, reset, divisor and collision.
module tb_tick_gen;
    import tick_pkg::*;

    localparam int PRESCALE = 4;
    localparam int CH       = 4;
    localparam int DIV_W    = 8;

    // ch3 D=0 periodic, ch2 D=5 one-shot, ch1 D=2 toggle, ch0 D=3 periodic
    localparam logic [CH*DIV_W-1:0] MAIN_DIV  = {8'd0, 8'd5, 8'd2, 8'd3};
    localparam logic [CH*2-1:0]     MAIN_MODE = {MODE_PERIODIC, MODE_ONESHOT,
                                                 MODE_TOGGLE, MODE_PERIODIC};

    typedef struct {
        int         edge_n;
        logic [3:0] start;
        logic [3:0] tick;
        logic [3:0] wave;
        logic [3:0] busy;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   n_checks = 0;
    int   n_err    = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    tick_gen_if #(.CH(CH), .DIV_W(DIV_W)) bus ();

    tick_gen #(
        .PRESCALE (PRESCALE),
        .CH       (CH),
        .DIV_W    (DIV_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Rising edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) check("wait_timeout", cyc, n);
    endtask

    task automatic apply_reset(input logic [CH*DIV_W-1:0] div, input logic [CH*2-1:0] mode);
        rst_n       = 1'b0;
        bus.en      = 1'b1;
        bus.div_i   = div;
        bus.mode_i  = mode;
        bus.start_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int bad;

        // edge, start applied after the check, expected tick/wave/busy
        vecs.push_back('{0,  4'b0000, 4'b0000, 4'b0000, 4'b0011});
        vecs.push_back('{3,  4'b0000, 4'b0000, 4'b0000, 4'b0011});
        vecs.push_back('{7,  4'b0100, 4'b0000, 4'b0000, 4'b0011});
        vecs.push_back('{8,  4'b0000, 4'b0010, 4'b0010, 4'b0111});
        vecs.push_back('{9,  4'b0000, 4'b0000, 4'b0010, 4'b0111});
        vecs.push_back('{11, 4'b0000, 4'b0000, 4'b0010, 4'b0111});
        vecs.push_back('{12, 4'b0000, 4'b0001, 4'b0010, 4'b0111});
        vecs.push_back('{13, 4'b0000, 4'b0000, 4'b0010, 4'b0111});
        vecs.push_back('{16, 4'b0000, 4'b0010, 4'b0000, 4'b0111});
        vecs.push_back('{24, 4'b0000, 4'b0011, 4'b0010, 4'b0111});
        vecs.push_back('{27, 4'b0000, 4'b0000, 4'b0010, 4'b0111});
        vecs.push_back('{28, 4'b0000, 4'b0100, 4'b0010, 4'b0011});
        vecs.push_back('{32, 4'b0000, 4'b0010, 4'b0000, 4'b0011});
        vecs.push_back('{36, 4'b0000, 4'b0001, 4'b0000, 4'b0011});
        vecs.push_back('{48, 4'b0000, 4'b0011, 4'b0000, 4'b0011});

        // Mixed four-channel run from the table.
        apply_reset(MAIN_DIV, MAIN_MODE);
        foreach (vecs[i]) begin
            wait_cyc(vecs[i].edge_n);
            check($sformatf("tick_e%0d", vecs[i].edge_n), bus.tick_o, vecs[i].tick);
            check($sformatf("wave_e%0d", vecs[i].edge_n), bus.wave_o, vecs[i].wave);
            check($sformatf("busy_e%0d", vecs[i].edge_n), bus.busy_o, vecs[i].busy);
            bus.start_i = vecs[i].start;
        end

        // One-shot stays quiet for 200 clocks after its tick at edge 28.
        bad = 0;
        while (cyc < 228) begin
            @(negedge clk);
            if (bus.tick_o[2] || bus.busy_o[2]) bad++;
        end
        check("oneshot_quiet", bad, 0);

        // Asynchronous reset mid-count, then timing restarts from power-up.
        apply_reset(MAIN_DIV, MAIN_MODE);
        wait_cyc(40);
        check("pre_rst_tick", bus.tick_o, 4'b0010);
        check("pre_rst_wave", bus.wave_o, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("rst_tick", bus.tick_o, 4'b0000);
        check("rst_wave", bus.wave_o, 4'b0000);
        check("rst_busy", bus.busy_o, 4'b0011);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(8);
        check("post_rst_tick8", bus.tick_o, 4'b0010);
        wait_cyc(12);
        check("post_rst_tick12", bus.tick_o, 4'b0001);

        // Enable low for edges 15..24 shifts every tick by 10 clocks.
        apply_reset(MAIN_DIV, MAIN_MODE);
        wait_cyc(14);
        bus.en = 1'b0;
        wait_cyc(20);
        check("en_off_wave", bus.wave_o, 4'b0010);
        check("en_off_tick20", bus.tick_o, 4'b0000);
        wait_cyc(24);
        check("en_off_tick24", bus.tick_o, 4'b0000);
        bus.en = 1'b1;
        wait_cyc(26);
        check("en_resume_tick26", bus.tick_o, 4'b0010);
        wait_cyc(34);
        check("en_resume_tick34", bus.tick_o, 4'b0011);

        // Divisor drops from 10 to 2 while ccnt = 7.
        apply_reset({24'd0, 8'd10}, 8'h00);
        wait_cyc(28);
        check("div_chg_tick28", bus.tick_o[0], 1'b0);
        wait_cyc(29);
        bus.div_i = {24'd0, 8'd2};
        wait_cyc(32);
        check("div_chg_tick32", bus.tick_o[0], 1'b1);
        wait_cyc(36);
        check("div_chg_tick36", bus.tick_o[0], 1'b0);
        wait_cyc(40);
        check("div_chg_tick40", bus.tick_o[0], 1'b1);
        wait_cyc(44);
        check("div_chg_tick44", bus.tick_o[0], 1'b0);
        wait_cyc(48);
        check("div_chg_tick48", bus.tick_o[0], 1'b1);

        // Divisor 1 ticks on every strobe.
        apply_reset({24'd0, 8'd1}, 8'h00);
        wait_cyc(4);
        check("d1_tick4", bus.tick_o[0], 1'b1);
        wait_cyc(5);
        check("d1_tick5", bus.tick_o[0], 1'b0);
        wait_cyc(7);
        check("d1_tick7", bus.tick_o[0], 1'b0);
        wait_cyc(8);
        check("d1_tick8", bus.tick_o[0], 1'b1);

        // Start in the wrap cycle suppresses that tick; D=0 channel ignores start.
        apply_reset({24'd0, 8'd3}, 8'h00);
        wait_cyc(11);
        bus.start_i = 4'b1001;
        wait_cyc(12);
        check("coll_tick12", bus.tick_o[0], 1'b0);
        check("coll_busy0", bus.busy_o[0], 1'b1);
        check("coll_busy3", bus.busy_o[3], 1'b0);
        bus.start_i = 4'b0000;
        wait_cyc(23);
        check("coll_tick23", bus.tick_o[0], 1'b0);
        wait_cyc(24);
        check("coll_tick24", bus.tick_o[0], 1'b1);
        wait_cyc(25);
        check("coll_tick25", bus.tick_o[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
